alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Execute-stage initiator for the combinational ALU.
- Accepts one operation per handshake from decode and registers the operands.
- Drives the ALU control/data ports, waits for ALU done, captures result and flags, and presents the result to writeback over a valid/ready handshake.
- Owns the architectural Z/V/N flag register; shift ops leave it unchanged.

Parameters:
- DATA_W, 16, operand/result width.
- TIMEOUT, 8, max cycles in EXEC waiting for alu_done before abort (range 2..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents op
- in_ready  out  1  block can accept op
- in_ctrl  in  3  ALU opcode: ADD=000, SUB=001, NAND=010, XOR=011, INC=100, SRA=101, SRL=110, SLL=111
- in_op_a  in  DATA_W  operand one
- in_op_b  in  DATA_W  operand two
- in_shamt  in  4  shift amount
- in_imm8  in  8  LHB/LLB immediate (passed through)
- in_rd  in  4  destination register tag
- alu_control  out  3  to ALU
- alu_data_one  out  DATA_W  to ALU
- alu_data_two  out  DATA_W  to ALU
- alu_shift  out  4  to ALU
- alu_load_half_imm  out  8  to ALU
- alu_done  in  1  ALU result valid
- alu_result  in  DATA_W  ALU result
- alu_flags  in  3  ALU flags {Z,V,N}
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  writeback accepts
- wb_rd  out  4  destination tag
- wb_data  out  DATA_W  captured result
- flags_q  out  3  architectural {Z,V,N}
- err_timeout  out  1  sticky timeout error
- err_clr  in  1  clears err_timeout

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE, operand registers 0, wb_valid 0, wb_rd 0, wb_data 0, flags_q 000, err_timeout 0, cycle counter 0. in_ready is 1 once rst_n deasserts.
- ALU outputs are driven only from registered operands, never combinationally from in_*. They hold their last values outside EXEC.
- FSM states and transitions:
  - IDLE: in_ready=1. If in_valid, latch ctrl/a/b/shamt/imm8/rd, clear counter, go to EXEC.
  - EXEC: in_ready=0; counter increments each cycle.
    - If alu_done: load wb_data=alu_result and wb_rd; update flags (rule below); go to WB.
    - Else, if counter==TIMEOUT-1: set err_timeout, leave flags unchanged, go to IDLE with no writeback.
  - WB: wb_valid=1, in_ready=0, wb_data/wb_rd stable. If wb_ready, go to IDLE. Otherwise stall indefinitely.
- Latency with combinational done: op accepted cycle 0, EXEC cycle 1, wb_valid cycle 2. Peak throughput is one op per 3 cycles.
- Flag update rule, applied at the EXEC capture edge only:
  - ctrl in {000,001,010,011,100}: flags_q <= alu_flags.
  - ctrl in {101,110,111}: flags_q is held.
- flags_q is registered, so a new value is visible the cycle after capture, i.e. coincident with wb_valid rising.
- in_valid while not in IDLE is ignored; decode must hold it until in_ready.
- err_clr and a simultaneous timeout in the same cycle: the set wins.
- Reset mid-operation (any state): abort immediately to reset values. No wb_valid pulse follows.
- Width: all datapath is DATA_W, no extension or truncation by this block.

Optional Feature:
- Macro: ALU_ISSUE_BRANCH_EN.
- When defined, adds ports br_cond (in, 3) and br_taken (out, 1). br_taken is a combinational function of flags_q:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GTE: Z|!N
  - 101 LTE: Z|N
  - 110 OVFL: V
  - 111 UNCOND: 1
- When not defined, these ports and the logic do not exist.

Decomposition:
- Package alu_pkg:
  - alu_ctrl_e enum for the 3-bit opcodes.
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - br_cond_e enum.
  - function writes_flags(ctrl).
- One sub-module, alu_flag_reg: flag register plus update rule plus optional branch evaluator.

Test Plan:
- ADD: in_ctrl=000, a=0x0003, b=0x0004; bench ALU returns done=1, result 0x0007, flags 000. Expect wb_valid at cycle 2 with wb_data=0x0007 and wb_rd as sent; flags_q=000.
- SUB then SLL:
  - SUB with bench flags 101 -> flags_q=101.
  - Next SLL, a=0x0001, shamt=4, result 0x0010, bench flags 000 -> wb_data=0x0010, flags_q stays 101.
- Backpressure: hold wb_ready=0 for 5 cycles with in_valid=1 -> wb_valid and wb_data stable, in_ready=0 throughout. Second op is accepted only after the wb_ready handshake.
- Timeout: bench keeps alu_done=0 -> after TIMEOUT=8 EXEC cycles, err_timeout=1, no wb_valid, flags unchanged. Pulse err_clr -> err_timeout=0.
- Reset in EXEC: assert rst_n=0 one cycle after acceptance -> all outputs return to reset values asynchronously, no writeback after release.
- ALU_ISSUE_BRANCH_EN: with flags_q=100, br_cond=001 -> br_taken=1, br_cond=000 -> 0. With flags_q=010, br_cond=110 -> br_taken=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU issue controller: opcodes, flag bit
// positions, branch conditions, FSM states and the flag-write predicate.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_NAND = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_INC  = 3'b100,
    ALU_SRA  = 3'b101,
    ALU_SRL  = 3'b110,
    ALU_SLL  = 3'b111
  } alu_ctrl_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    BR_NEQ    = 3'b000,
    BR_EQ     = 3'b001,
    BR_GT     = 3'b010,
    BR_LT     = 3'b011,
    BR_GTE    = 3'b100,
    BR_LTE    = 3'b101,
    BR_OVFL   = 3'b110,
    BR_UNCOND = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } issue_state_e;

  // Shifts are not allowed to disturb the architectural flags.
  function automatic logic writes_flags(input alu_ctrl_e ctrl);
    case (ctrl)
      ALU_SRA, ALU_SRL, ALU_SLL: writes_flags = 1'b0;
      default:                   writes_flags = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural {Z,V,N} flag register with opcode-qualified update.
// Optional branch evaluator enabled by `define ALU_ISSUE_BRANCH_EN.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      capture,
  input  alu_ctrl_e ctrl,
  input  logic [2:0] alu_flags,
  output logic [2:0] flags_q
`ifdef ALU_ISSUE_BRANCH_EN
  ,
  input  logic [2:0] br_cond,
  output logic       br_taken
`endif
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (capture && writes_flags(ctrl)) begin
      flags_q <= alu_flags;
    end
  end

`ifdef ALU_ISSUE_BRANCH_EN
  logic flag_z, flag_v, flag_n;

  assign flag_z = flags_q[FLAG_Z];
  assign flag_v = flags_q[FLAG_V];
  assign flag_n = flags_q[FLAG_N];

  always_comb begin
    br_taken = 1'b0;
    case (br_cond_e'(br_cond))
      BR_NEQ:    br_taken = !flag_z;
      BR_EQ:     br_taken = flag_z;
      BR_GT:     br_taken = !flag_z && !flag_n;
      BR_LT:     br_taken = flag_n;
      BR_GTE:    br_taken = flag_z || !flag_n;
      BR_LTE:    br_taken = flag_z || flag_n;
      BR_OVFL:   br_taken = flag_v;
      BR_UNCOND: br_taken = 1'b1;
      default:   br_taken = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage initiator: latches one op from decode, drives the ALU, waits
// for done (with timeout), and hands the result to writeback. Optional branch
// evaluator enabled by `define ALU_ISSUE_BRANCH_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ctrl,
  input  logic [DATA_W-1:0] in_op_a,
  input  logic [DATA_W-1:0] in_op_b,
  input  logic [3:0]        in_shamt,
  input  logic [7:0]        in_imm8,
  input  logic [3:0]        in_rd,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_data_one,
  output logic [DATA_W-1:0] alu_data_two,
  output logic [3:0]        alu_shift,
  output logic [7:0]        alu_load_half_imm,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags_q,
  output logic              err_timeout,
  input  logic              err_clr
`ifdef ALU_ISSUE_BRANCH_EN
  ,
  input  logic [2:0]        br_cond,
  output logic              br_taken
`endif
);

  issue_state_e      state;
  alu_ctrl_e         ctrl_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [3:0]        shamt_q;
  logic [7:0]        imm8_q;
  logic [3:0]        rd_q;
  logic [7:0]        cycle_cnt;
  logic              capture;
  logic              timeout_hit;

  // The ALU only ever sees the latched operands, so it is isolated from decode.
  assign alu_control       = ctrl_q;
  assign alu_data_one      = op_a_q;
  assign alu_data_two      = op_b_q;
  assign alu_shift         = shamt_q;
  assign alu_load_half_imm = imm8_q;

  assign capture     = (state == ST_EXEC) && alu_done;
  assign timeout_hit = (state == ST_EXEC) && !alu_done &&
                       (cycle_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ctrl_q      <= ALU_ADD;
      op_a_q      <= '0;
      op_b_q      <= '0;
      shamt_q     <= '0;
      imm8_q      <= '0;
      rd_q        <= '0;
      cycle_cnt   <= '0;
      in_ready    <= 1'b1;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      // A timeout in the same cycle as err_clr keeps the error set.
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end else if (err_clr) begin
        err_timeout <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            ctrl_q    <= alu_ctrl_e'(in_ctrl);
            op_a_q    <= in_op_a;
            op_b_q    <= in_op_b;
            shamt_q   <= in_shamt;
            imm8_q    <= in_imm8;
            rd_q      <= in_rd;
            cycle_cnt <= '0;
            in_ready  <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cycle_cnt <= cycle_cnt + 8'd1;
          if (alu_done) begin
            wb_data  <= alu_result;
            wb_rd    <= rd_q;
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end else if (timeout_hit) begin
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            in_ready <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

  alu_flag_reg u_flag_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .ctrl      (ctrl_q),
    .alu_flags (alu_flags),
    .flags_q   (flags_q)
`ifdef ALU_ISSUE_BRANCH_EN
    ,
    .br_cond   (br_cond),
    .br_taken  (br_taken)
`endif
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table of single ops plus timeout,
// backpressure and reset sequences. Branch checks under ALU_ISSUE_BRANCH_EN.
module tb_alu_issue_ctrl;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_ctrl;
  logic [DATA_W-1:0] in_op_a;
  logic [DATA_W-1:0] in_op_b;
  logic [3:0]        in_shamt;
  logic [7:0]        in_imm8;
  logic [3:0]        in_rd;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_data_one;
  logic [DATA_W-1:0] alu_data_two;
  logic [3:0]        alu_shift;
  logic [7:0]        alu_load_half_imm;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic [2:0]        alu_flags;
  logic              wb_valid;
  logic              wb_ready;
  logic [3:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        flags_q;
  logic              err_timeout;
  logic              err_clr;
`ifdef ALU_ISSUE_BRANCH_EN
  logic [2:0]        br_cond;
  logic              br_taken;
`endif

  int checks;
  int errors;

  alu_issue_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_ctrl           (in_ctrl),
    .in_op_a           (in_op_a),
    .in_op_b           (in_op_b),
    .in_shamt          (in_shamt),
    .in_imm8           (in_imm8),
    .in_rd             (in_rd),
    .alu_control       (alu_control),
    .alu_data_one      (alu_data_one),
    .alu_data_two      (alu_data_two),
    .alu_shift         (alu_shift),
    .alu_load_half_imm (alu_load_half_imm),
    .alu_done          (alu_done),
    .alu_result        (alu_result),
    .alu_flags         (alu_flags),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .flags_q           (flags_q),
    .err_timeout       (err_timeout),
    .err_clr           (err_clr)
`ifdef ALU_ISSUE_BRANCH_EN
    ,
    .br_cond           (br_cond),
    .br_taken          (br_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic [7:0]  imm;
    logic [3:0]  rd;
    logic [15:0] res;
    logic [2:0]  aflags;
    logic [2:0]  exp_flags;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i);
    in_valid   = 1'b1;
    in_ctrl    = vecs[i].ctrl;
    in_op_a    = vecs[i].a;
    in_op_b    = vecs[i].b;
    in_shamt   = vecs[i].shamt;
    in_imm8    = vecs[i].imm;
    in_rd      = vecs[i].rd;
    alu_done   = 1'b1;
    alu_result = vecs[i].res;
    alu_flags  = vecs[i].aflags;
    wb_ready   = 1'b1;
  endtask

  task automatic runSimpleOp(input logic [2:0] ctrl, input logic [15:0] res,
                             input logic [2:0] fl);
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = ctrl; in_op_a = 16'h0001; in_op_b = 16'h0001;
    in_shamt = 4'd0; in_rd = 4'd1; alu_done = 1'b1; alu_result = res;
    alu_flags = fl; wb_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] prev_flags;
    checks = 0;
    errors = 0;

    //        ctrl     a         b         sh    imm    rd    result    aflg    expflg
    vecs[0] = '{3'b000, 16'h0003, 16'h0004, 4'd0, 8'hA0, 4'd5, 16'h0007, 3'b000, 3'b000};
    vecs[1] = '{3'b001, 16'h0005, 16'h0005, 4'd0, 8'hA1, 4'd2, 16'h0000, 3'b101, 3'b101};
    vecs[2] = '{3'b111, 16'h0001, 16'h0000, 4'd4, 8'hA2, 4'd3, 16'h0010, 3'b000, 3'b101};
    vecs[3] = '{3'b011, 16'hFF00, 16'h0FF0, 4'd0, 8'hA3, 4'd9, 16'hF0F0, 3'b001, 3'b001};
    vecs[4] = '{3'b101, 16'h8000, 16'h0000, 4'd3, 8'hA4, 4'd4, 16'hF000, 3'b110, 3'b001};
    vecs[5] = '{3'b100, 16'h7FFF, 16'h0000, 4'd0, 8'hA5, 4'd15, 16'h8000, 3'b011, 3'b011};
    vecs[6] = '{3'b010, 16'hFFFF, 16'hFFFF, 4'd0, 8'hA6, 4'd7, 16'h0000, 3'b100, 3'b100};
    vecs[7] = '{3'b110, 16'h8000, 16'h0000, 4'd15, 8'hA7, 4'd1, 16'h0001, 3'b000, 3'b100};

    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = 3'b000; in_op_a = '0; in_op_b = '0;
    in_shamt = '0; in_imm8 = '0; in_rd = '0; alu_done = 1'b0; alu_result = '0;
    alu_flags = '0; wb_ready = 1'b1; err_clr = 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
    br_cond = 3'b000;
`endif

    #2;
    checkOutput("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst_wb_data", {16'd0, wb_data}, 32'd0);
    checkOutput("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    checkOutput("rst_flags", {29'd0, flags_q}, 32'd0);
    checkOutput("rst_err", {31'd0, err_timeout}, 32'd0);
    checkOutput("rst_alu_a", {16'd0, alu_data_one}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    prev_flags = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput($sformatf("v%0d_exec_in_ready", i), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("v%0d_exec_wb_valid", i), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("v%0d_alu_control", i), {29'd0, alu_control}, {29'd0, vecs[i].ctrl});
      checkOutput($sformatf("v%0d_alu_a", i), {16'd0, alu_data_one}, {16'd0, vecs[i].a});
      checkOutput($sformatf("v%0d_alu_b", i), {16'd0, alu_data_two}, {16'd0, vecs[i].b});
      checkOutput($sformatf("v%0d_alu_shift", i), {28'd0, alu_shift}, {28'd0, vecs[i].shamt});
      checkOutput($sformatf("v%0d_alu_imm", i), {24'd0, alu_load_half_imm}, {24'd0, vecs[i].imm});
      checkOutput($sformatf("v%0d_exec_flags", i), {29'd0, flags_q}, {29'd0, prev_flags});
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
      checkOutput($sformatf("v%0d_wb_data", i), {16'd0, wb_data}, {16'd0, vecs[i].res});
      checkOutput($sformatf("v%0d_wb_rd", i), {28'd0, wb_rd}, {28'd0, vecs[i].rd});
      checkOutput($sformatf("v%0d_flags", i), {29'd0, flags_q}, {29'd0, vecs[i].exp_flags});
      checkOutput($sformatf("v%0d_wb_in_ready", i), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_done_wb_valid", i), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("v%0d_done_in_ready", i), {31'd0, in_ready}, 32'd1);
      prev_flags = vecs[i].exp_flags;
    end

    // Timeout: ALU never answers; flags must stay at 100, no writeback.
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 3'b000; in_op_a = 16'h1111; in_op_b = 16'h2222;
    in_rd = 4'd8; alu_done = 1'b0; alu_result = 16'hDEAD; alu_flags = 3'b011;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("to_busy_%0d", k), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("to_nowb_%0d", k), {31'd0, wb_valid}, 32'd0);
      checkOutput($sformatf("to_noerr_%0d", k), {31'd0, err_timeout}, 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("to_err_set", {31'd0, err_timeout}, 32'd1);
    checkOutput("to_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("to_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("to_flags_held", {29'd0, flags_q}, 32'b100);
    checkOutput("to_wb_data_held", {16'd0, wb_data}, 32'h0001);
    @(posedge clk); #1;
    checkOutput("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("to_err_clr", {31'd0, err_timeout}, 32'd0);
    @(negedge clk); err_clr = 1'b0;

    // Backpressure: writeback stalls 5 cycles while decode offers a second op.
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 3'b000; in_op_a = 16'h0001; in_op_b = 16'h0001;
    in_shamt = 4'd0; in_rd = 4'd6; alu_done = 1'b1; alu_result = 16'h0002;
    alu_flags = 3'b000; wb_ready = 1'b0;
    @(posedge clk); #1;
    in_op_a = 16'h0009; in_op_b = 16'h0009; in_rd = 4'd7;
    @(posedge clk); #1;
    checkOutput("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("bp_wb_data", {16'd0, wb_data}, 32'h0002);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_hold_valid_%0d", k), {31'd0, wb_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_data_%0d", k), {16'd0, wb_data}, 32'h0002);
      checkOutput($sformatf("bp_hold_rd_%0d", k), {28'd0, wb_rd}, 32'd6);
      checkOutput($sformatf("bp_hold_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      checkOutput($sformatf("bp_hold_opa_%0d", k), {16'd0, alu_data_one}, 32'h0001);
    end
    @(negedge clk);
    wb_ready = 1'b1; alu_result = 16'h0012; alu_flags = 3'b011;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_opa", {16'd0, alu_data_one}, 32'h0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_op2_busy", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_op2_opa", {16'd0, alu_data_one}, 32'h0009);
    @(posedge clk); #1;
    checkOutput("bp_op2_wb_valid", {31'd0, wb_valid}, 32'd1);
    checkOutput("bp_op2_wb_data", {16'd0, wb_data}, 32'h0012);
    checkOutput("bp_op2_wb_rd", {28'd0, wb_rd}, 32'd7);
    checkOutput("bp_op2_flags", {29'd0, flags_q}, 32'b011);
    @(posedge clk); #1;
    checkOutput("bp_op2_done", {31'd0, wb_valid}, 32'd0);

    // Reset one cycle into EXEC: everything returns to reset values at once.
    @(negedge clk);
    in_valid = 1'b1; in_ctrl = 3'b001; in_op_a = 16'h4444; in_op_b = 16'h1111;
    in_rd = 4'd3; alu_done = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("mid_rst_wb_data", {16'd0, wb_data}, 32'd0);
    checkOutput("mid_rst_wb_rd", {28'd0, wb_rd}, 32'd0);
    checkOutput("mid_rst_flags", {29'd0, flags_q}, 32'd0);
    checkOutput("mid_rst_opa", {16'd0, alu_data_one}, 32'd0);
    @(negedge clk);
    alu_done = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("post_rst_nowb_%0d", k), {31'd0, wb_valid}, 32'd0);
    end

`ifdef ALU_ISSUE_BRANCH_EN
    runSimpleOp(3'b000, 16'h0000, 3'b100);
    br_cond = 3'b001; #1;
    checkOutput("br_eq_z", {31'd0, br_taken}, 32'd1);
    br_cond = 3'b000; #1;
    checkOutput("br_neq_z", {31'd0, br_taken}, 32'd0);
    br_cond = 3'b100; #1;
    checkOutput("br_gte_z", {31'd0, br_taken}, 32'd1);
    runSimpleOp(3'b000, 16'h7FFF, 3'b010);
    br_cond = 3'b110; #1;
    checkOutput("br_ovfl_v", {31'd0, br_taken}, 32'd1);
    br_cond = 3'b011; #1;
    checkOutput("br_lt_v", {31'd0, br_taken}, 32'd0);
    br_cond = 3'b010; #1;
    checkOutput("br_gt_v", {31'd0, br_taken}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
